// File: rtl/serial_dp_loader_if.sv
// Bus bundle for serial_dp_loader: load control, serial input and memory write port.
interface serial_dp_loader_if #(
   parameter int unsigned WORD_W       = 16,
   parameter int unsigned MAX_FEATURES = 15,
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned LANES        = 1
);
   logic                                 START;
   logic [3:0]                           FEAT;
   logic [ADDR_WIDTH-1:0]                DATA_POINTS;
   logic [LANES-1:0]                     S;
   logic                                 S_VALID;
   logic                                 WR_EN;
   logic [ADDR_WIDTH-1:0]                WR_ADDR;
   logic [WORD_W*(MAX_FEATURES+1)-1:0]   WR_DATA;
   logic                                 BUSY;
   logic                                 DONE;
   logic                                 ERR;

   // Loader side.
   modport slave (
      input  START, FEAT, DATA_POINTS, S, S_VALID,
      output WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERR
   );

   // Stimulus / host side.
   modport master (
      output START, FEAT, DATA_POINTS, S, S_VALID,
      input  WR_EN, WR_ADDR, WR_DATA, BUSY, DONE, ERR
   );
endinterface

// File: rtl/serial_dp_loader.sv
// Multi-lane serial-to-parallel loader: assembles words from qualified serial lanes, packs
// FEAT+1 words per record (highest word first) and writes records at incrementing addresses.
module serial_dp_loader #(
   parameter int unsigned WORD_W       = 16,
   parameter int unsigned MAX_FEATURES = 15,
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned LANES        = 1,
   parameter bit          MSB_FIRST    = 1'b0
) (
   input logic               CLK,
   input logic               RST_N,
   serial_dp_loader_if.slave bus
);
   localparam int unsigned REC_W = WORD_W * (MAX_FEATURES + 1);
   localparam int unsigned BW    = $clog2(WORD_W);
   localparam logic [3:0]    MaxFeat = 4'(MAX_FEATURES);
   localparam logic [BW-1:0] LastBit = BW'(WORD_W - LANES);

   typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

   state_e                r_state_q,    w_state_d;
   logic [3:0]            r_feat_q,     w_feat_d;
   logic [ADDR_WIDTH-1:0] r_dp_q,       w_dp_d;
   logic [BW-1:0]         r_bit_cnt_q,  w_bit_cnt_d;
   logic [3:0]            r_word_idx_q, w_word_idx_d;
   logic [ADDR_WIDTH-1:0] r_rec_cnt_q,  w_rec_cnt_d;
   logic [WORD_W-1:0]     r_word_q,     w_word_d;
   logic [REC_W-1:0]      r_buf_q,      w_buf_d;
   logic                  r_wr_en_q,    w_wr_en_d;
   logic [ADDR_WIDTH-1:0] r_wr_addr_q,  w_wr_addr_d;
   logic [REC_W-1:0]      r_wr_data_q,  w_wr_data_d;
   logic                  r_err_q,      w_err_d;

   logic [WORD_W-1:0]     w_word;
   logic [REC_W-1:0]      w_buf;
   logic [BW-1:0]         w_bidx;

   // State register and all datapath registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state_q    <= StIdle;
         r_feat_q     <= '0;
         r_dp_q       <= '0;
         r_bit_cnt_q  <= '0;
         r_word_idx_q <= '0;
         r_rec_cnt_q  <= '0;
         r_word_q     <= '0;
         r_buf_q      <= '0;
         r_wr_en_q    <= 1'b0;
         r_wr_addr_q  <= '0;
         r_wr_data_q  <= '0;
         r_err_q      <= 1'b0;
      end else begin
         r_state_q    <= w_state_d;
         r_feat_q     <= w_feat_d;
         r_dp_q       <= w_dp_d;
         r_bit_cnt_q  <= w_bit_cnt_d;
         r_word_idx_q <= w_word_idx_d;
         r_rec_cnt_q  <= w_rec_cnt_d;
         r_word_q     <= w_word_d;
         r_buf_q      <= w_buf_d;
         r_wr_en_q    <= w_wr_en_d;
         r_wr_addr_q  <= w_wr_addr_d;
         r_wr_data_q  <= w_wr_data_d;
         r_err_q      <= w_err_d;
      end
   end

   // Next-state: start/error handling, lane sampling, word and record completion.
   always_comb begin
      w_state_d    = r_state_q;
      w_feat_d     = r_feat_q;
      w_dp_d       = r_dp_q;
      w_bit_cnt_d  = r_bit_cnt_q;
      w_word_idx_d = r_word_idx_q;
      w_rec_cnt_d  = r_rec_cnt_q;
      w_word_d     = r_word_q;
      w_buf_d      = r_buf_q;
      w_wr_en_d    = 1'b0;
      w_wr_addr_d  = r_wr_addr_q;
      w_wr_data_d  = r_wr_data_q;
      w_err_d      = r_err_q;
      w_word       = r_word_q;
      w_buf        = r_buf_q;
      w_bidx       = '0;

      unique case (r_state_q)
         StIdle, StDone: begin
            if (bus.START) begin
               if (bus.FEAT > MaxFeat) begin
                  w_err_d = 1'b1;
               end else begin
                  w_feat_d     = bus.FEAT;
                  w_dp_d       = bus.DATA_POINTS;
                  w_err_d      = 1'b0;
                  w_bit_cnt_d  = '0;
                  w_word_idx_d = bus.FEAT;
                  w_rec_cnt_d  = '0;
                  w_word_d     = '0;
                  w_buf_d      = '0;
                  w_state_d    = StLoad;
               end
            end else if (r_state_q == StDone && bus.S_VALID) begin
               // Data after the final record is an overrun; it is dropped.
               w_err_d = 1'b1;
            end
         end
         StLoad: begin
            if (bus.S_VALID) begin
               for (int k = 0; k < int'(LANES); k++) begin
                  if (MSB_FIRST) w_bidx = BW'(WORD_W - 1) - r_bit_cnt_q - BW'(k);
                  else           w_bidx = r_bit_cnt_q + BW'(k);
                  w_word[w_bidx] = bus.S[k];
               end
               w_word_d = w_word;
               if (r_bit_cnt_q == LastBit) begin
                  w_bit_cnt_d = '0;
                  w_word_d    = '0;
                  for (int j = 0; j <= int'(MAX_FEATURES); j++) begin
                     if (r_word_idx_q == 4'(j)) w_buf[j*WORD_W +: WORD_W] = w_word;
                  end
                  if (r_word_idx_q != 4'd0) begin
                     w_word_idx_d = r_word_idx_q - 4'd1;
                     w_buf_d      = w_buf;
                  end else begin
                     // Record complete: publish it and re-arm the buffer on the same edge.
                     w_wr_en_d    = 1'b1;
                     w_wr_addr_d  = r_rec_cnt_q;
                     w_wr_data_d  = w_buf;
                     w_buf_d      = '0;
                     w_word_idx_d = r_feat_q;
                     if (r_rec_cnt_q == r_dp_q) w_state_d   = StDone;
                     else                       w_rec_cnt_d = r_rec_cnt_q + 1'b1;
                  end
               end else begin
                  w_bit_cnt_d = r_bit_cnt_q + BW'(LANES);
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign bus.WR_EN   = r_wr_en_q;
   assign bus.WR_ADDR = r_wr_addr_q;
   assign bus.WR_DATA = r_wr_data_q;
   assign bus.BUSY    = (r_state_q == StLoad);
   assign bus.DONE    = (r_state_q == StDone);
   assign bus.ERR     = r_err_q;
endmodule
